// File: rtl/dp_issue_ctrl.sv
// dp_issue_ctrl: issue controller for a downstream combinational datapath.
//
// Commands {opcode, a, b} are queued in a FIFO_DEPTH-entry FIFO (a power of
// two, 2..16). The FIFO head drives the datapath. The datapath result is
// captured into a one-entry output register that has valid/ready handshaking.
// The queued path adds one cycle of latency. With out_ready held high, the
// block accepts one command and retires one result every cycle.
//
// Optional feature: define DP_CARRY_CNT_EN to add carry_cnt. This is a
// saturating count of captured results whose dp_co was 1.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           command handshake (in_ready = !full)
//   in_opcode, in_a, in_b       command opcode and signed operands
//   dp_opcode, dp_a, dp_b       FIFO head driven to the datapath (0 when empty)
//   dp_y, dp_co                 datapath result and carry-out
//   out_valid/out_ready         result handshake
//   out_y, out_co, out_opcode   registered result, carry and opcode tag
//   busy                        FIFO non-empty or result pending
//   carry_cnt                   (DP_CARRY_CNT_EN only) saturating carry count
module dp_issue_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_opcode,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic [15:0] dp_a,
    output logic [15:0] dp_b,
    output logic [2:0]  dp_opcode,
    input  logic [15:0] dp_y,
    input  logic        dp_co,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_y,
    output logic        out_co,
    output logic [2:0]  out_opcode,
    output logic        busy
`ifdef DP_CARRY_CNT_EN
    ,
    output logic [15:0] carry_cnt
`endif
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

    typedef enum logic [0:0] {OutEmpty, OutFull} out_state_e;

    out_state_e state_q;

    logic [2:0]  mem_op_q [FIFO_DEPTH];
    logic [15:0] mem_a_q  [FIFO_DEPTH];
    logic [15:0] mem_b_q  [FIFO_DEPTH];

    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] cnt_q;

    logic empty, full, push, capture;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == FullCnt);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    // The output register is free when it is empty or is being drained this cycle.
    assign capture  = !empty && ((state_q == OutEmpty) || out_ready);
    assign busy     = !empty || out_valid;

    // Gate the head with empty so stale storage never reaches the datapath.
    always_comb begin
        dp_a      = '0;
        dp_b      = '0;
        dp_opcode = '0;
        if (!empty) begin
            dp_a      = mem_a_q[rptr_q];
            dp_b      = mem_b_q[rptr_q];
            dp_opcode = mem_op_q[rptr_q];
        end
    end

    // Storage needs no reset: it is only observed through the empty gate above.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_op_q[wptr_q] <= in_opcode;
            mem_a_q[wptr_q]  <= in_a;
            mem_b_q[wptr_q]  <= in_b;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (capture) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push && !capture) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!push && capture) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Output stage FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OutEmpty;
            out_valid  <= 1'b0;
            out_y      <= '0;
            out_co     <= 1'b0;
            out_opcode <= '0;
        end else begin
            unique case (state_q)
                OutEmpty: begin
                    if (capture) begin
                        state_q    <= OutFull;
                        out_valid  <= 1'b1;
                        out_y      <= dp_y;
                        out_co     <= dp_co;
                        out_opcode <= dp_opcode;
                    end
                end
                OutFull: begin
                    if (capture) begin
                        out_y      <= dp_y;
                        out_co     <= dp_co;
                        out_opcode <= dp_opcode;
                    end else if (out_ready) begin
                        state_q   <= OutEmpty;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= OutEmpty;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef DP_CARRY_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_cnt <= '0;
        end else if (capture && dp_co && (carry_cnt != 16'hFFFF)) begin
            carry_cnt <= carry_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dp_issue_ctrl.sv
// Self-checking bench for dp_issue_ctrl (FIFO_DEPTH = 4).
//
// The bench supplies a small combinational datapath model:
//   000 add (17-bit carry), 001 subtract (borrow in carry), others XOR (co=0).
module tb_dp_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_opcode;
    logic [15:0] in_a, in_b;
    logic [15:0] dp_a, dp_b;
    logic [2:0]  dp_opcode;
    logic [15:0] dp_y;
    logic        dp_co;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_y;
    logic        out_co;
    logic [2:0]  out_opcode;
    logic        busy;
`ifdef DP_CARRY_CNT_EN
    logic [15:0] carry_cnt;
`endif

    int n_cmp;
    int n_bad;

    dp_issue_ctrl #(
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_opcode  (dp_opcode),
        .dp_y       (dp_y),
        .dp_co      (dp_co),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_co     (out_co),
        .out_opcode (out_opcode),
        .busy       (busy)
`ifdef DP_CARRY_CNT_EN
        ,
        .carry_cnt  (carry_cnt)
`endif
    );

    always_comb begin
        unique case (dp_opcode)
            3'b000:  {dp_co, dp_y} = {1'b0, dp_a} + {1'b0, dp_b};
            3'b001:  {dp_co, dp_y} = {1'b0, dp_a} - {1'b0, dp_b};
            default: {dp_co, dp_y} = {1'b0, dp_a ^ dp_b};
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
        logic        co;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{3'b000, 16'd5,     16'd128,   16'd133,   1'b0};
        vecs[1] = '{3'b000, 16'hFFFF,  16'd1,     16'd0,     1'b1};
        vecs[2] = '{3'b001, 16'd10,    16'd3,     16'd7,     1'b0};
        vecs[3] = '{3'b001, 16'd3,     16'd10,    16'hFFF9,  1'b1};
        vecs[4] = '{3'b000, 16'h7FFF,  16'd1,     16'h8000,  1'b0};
        vecs[5] = '{3'b010, 16'h00FF,  16'h0F0F,  16'h0FF0,  1'b0};
        vecs[6] = '{3'b111, 16'hAAAA,  16'h5555,  16'hFFFF,  1'b0};
        vecs[7] = '{3'b000, 16'h8000,  16'h8000,  16'h0000,  1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_opcode = 3'b000;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        // Reset state
        #3;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst out_y", 32'(out_y), 32'd0);
        check("rst out_co", 32'(out_co), 32'd0);
        check("rst out_opcode", 32'(out_opcode), 32'd0);
        check("rst dp_a", 32'(dp_a), 32'd0);
        check("rst dp_b", 32'(dp_b), 32'd0);
        check("rst dp_opcode", 32'(dp_opcode), 32'd0);
`ifdef DP_CARRY_CNT_EN
        check("rst carry_cnt", 32'(carry_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single operations from the vector table, one at a time
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            in_opcode = vecs[i].op;
            in_a      = vecs[i].a;
            in_b      = vecs[i].b;
            step();
            in_valid = 1'b0;
            check("vec head dp_a", 32'(dp_a), 32'(vecs[i].a));
            check("vec head dp_opcode", 32'(dp_opcode), 32'(vecs[i].op));
            check("vec latency out_valid", 32'(out_valid), 32'd0);
            step();
            check("vec out_valid", 32'(out_valid), 32'd1);
            check("vec out_y", 32'(out_y), 32'(vecs[i].y));
            check("vec out_co", 32'(out_co), 32'(vecs[i].co));
            check("vec out_opcode", 32'(out_opcode), 32'(vecs[i].op));
            check("vec empty dp_a", 32'(dp_a), 32'd0);
            step();
            check("vec drained out_valid", 32'(out_valid), 32'd0);
            check("vec drained busy", 32'(busy), 32'd0);
        end
`ifdef DP_CARRY_CNT_EN
        check("vec carry_cnt", 32'(carry_cnt), 32'd3);
`endif

        // Backpressure: 5 commands fit (4 queued + 1 registered)
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp in_ready before push", 32'(in_ready), 32'd1);
            in_valid  = 1'b1;
            in_opcode = 3'b000;
            in_a      = 16'(100 + i);
            in_b      = 16'(i);
            step();
        end
        in_valid = 1'b0;
        check("bp in_ready full", 32'(in_ready), 32'd0);
        check("bp out_valid", 32'(out_valid), 32'd1);
        check("bp out_y first", 32'(out_y), 32'd100);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp out_y hold", 32'(out_y), 32'd100);
            check("bp in_ready hold", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            step();
            check("bp drain out_valid", 32'(out_valid), 32'd1);
            check("bp drain out_y", 32'(out_y), 32'(100 + 2 * k));
            check("bp drain in_ready", 32'(in_ready), 32'd1);
        end
        step();
        check("bp end out_valid", 32'(out_valid), 32'd0);
        check("bp end busy", 32'(busy), 32'd0);

        // Streaming: one result per cycle, pointers wrap several times
        for (int c = 0; c <= 20; c++) begin
            if (c < 20) begin
                in_valid  = 1'b1;
                in_opcode = 3'b000;
                in_a      = 16'(3 * c);
                in_b      = 16'd7;
                check("stream in_ready", 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (c >= 1) begin
                check("stream out_valid", 32'(out_valid), 32'd1);
                check("stream out_y", 32'(out_y), 32'(3 * (c - 1) + 7));
            end
        end
        step();
        check("stream end out_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset with 3 queued and a result pending
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_opcode = 3'b001;
            in_a      = 16'(50 + i);
            in_b      = 16'd1;
            step();
        end
        in_valid = 1'b0;
        check("mid pre out_valid", 32'(out_valid), 32'd1);
        check("mid pre out_y", 32'(out_y), 32'd49);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst in_ready", 32'(in_ready), 32'd1);
        check("mid rst out_y", 32'(out_y), 32'd0);
        check("mid rst dp_a", 32'(dp_a), 32'd0);
`ifdef DP_CARRY_CNT_EN
        check("mid rst carry_cnt", 32'(carry_cnt), 32'd0);
`endif
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post rst out_valid", 32'(out_valid), 32'd0);
            check("post rst busy", 32'(busy), 32'd0);
        end

`ifdef DP_CARRY_CNT_EN
        // Saturation: more than 65535 carry captures
        for (int i = 0; i < 65540; i++) begin
            in_valid  = 1'b1;
            in_opcode = 3'b000;
            in_a      = 16'hFFFF;
            in_b      = 16'd1;
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        check("sat carry_cnt", 32'(carry_cnt), 32'd65535);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dp_issue_ctrl.md
DP_ISSUE_CTRL -- requirements
Module: dp_issue_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, command FIFO depth; legal values are powers of two from 2 to 16.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  command offered.
REQ-005 in_ready  out  1  command FIFO can accept.
REQ-006 in_opcode  in  3  datapath opcode (000 sum … 111 Adi).
REQ-007 in_a, in_b  in  16 each  signed operands.
REQ-008 dp_a, dp_b  out  16 each  operands driven to the downstream combinational datapath.
REQ-009 dp_opcode  out  3  opcode driven to the datapath.
REQ-010 dp_y  in  16  datapath signed result.
REQ-011 dp_co  in  1  datapath carry-out.
REQ-012 out_valid  out  1  registered result available.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 out_y  out  16  registered result; out_co  out  1  registered carry; out_opcode  out  3  opcode tag of the result.
REQ-015 busy  out  1  high when the FIFO is non-empty or out_valid is high.

Function
REQ-016 Push SHALL occur on a clock edge with in_valid && in_ready; in_ready SHALL equal !full, with no same-cycle bypass when full.
REQ-017 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL range from 0 to FIFO_DEPTH.
REQ-018 dp_a/dp_b/dp_opcode SHALL be driven from the registered FIFO head entry; when the FIFO is empty they SHALL be 0/0/000.
REQ-019 The output stage SHALL be a two-state FSM: OUT_EMPTY (out_valid=0) and OUT_FULL (out_valid=1).
REQ-020 Capture SHALL occur when the FIFO is non-empty and (state==OUT_EMPTY or out_ready=1): dp_y, dp_co and the head opcode are registered, the head is popped, and state becomes OUT_FULL.
REQ-021 In OUT_FULL with out_ready=1 and an empty FIFO, state SHALL become OUT_EMPTY.
REQ-022 In OUT_FULL with out_ready=0, out_y/out_co/out_opcode SHALL hold stable.
REQ-023 Latency SHALL be one cycle: a command pushed at edge N into an empty FIFO with OUT_EMPTY gives out_valid=1 after edge N+1.
REQ-024 Simultaneous push and pop SHALL leave the count unchanged; a push into a full FIFO SHALL be impossible because in_ready=0.
REQ-025 Sustained throughput SHALL be one result per cycle while in_valid=1 and out_ready=1.
REQ-026 Results SHALL leave in command order; no command is dropped or duplicated.

Reset
REQ-027 While rst_n=0: FIFO emptied, pointers 0, state OUT_EMPTY, out_valid=0, out_y=0, out_co=0, out_opcode=000, in_ready=1, busy=0, dp_* = 0.
REQ-028 Reset asserted mid-operation SHALL discard all queued and registered results immediately, without waiting for a clock edge.

Configuration
REQ-029 Macro DP_CARRY_CNT_EN: when defined, the block SHALL add port carry_cnt (out, 16) as the count of captured results with dp_co=1.
REQ-030 carry_cnt SHALL saturate at 65535, clear on reset, and increment once per capture.
REQ-031 When DP_CARRY_CNT_EN is undefined, the carry_cnt port and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Single op: push sum A=5, B=128, out_ready=1 -> after 1 cycle out_valid=1, out_y=133, out_co=0, out_opcode=000.
REQ-033 Carry: push sum A=-1, B=1 -> out_y=0, out_co=1; with DP_CARRY_CNT_EN, carry_cnt=1.
REQ-034 Backpressure: out_ready=0, push 5 commands at FIFO_DEPTH=4 -> in_ready=0 after 5 accepted (4 in FIFO, 1 registered); out_y holds; releasing out_ready drains 5 results in order.
REQ-035 Wrap and simultaneous events: stream 20 back-to-back ops with out_ready=1 -> 1 result per cycle, correct order, count never exceeds 4.
REQ-036 Reset mid-stream: assert rst_n=0 with 3 queued and out_valid=1 -> out_valid=0, busy=0, in_ready=1 immediately; no stale result appears after release.
REQ-037 Saturation: with DP_CARRY_CNT_EN and counter preset near 65535 by 65536 carry ops -> carry_cnt stays 65535.
